// File: rtl/rgb_window_3x3.sv
// rgb_window_3x3: streaming 3x3 RGB neighbourhood generator with two cascaded
// line buffers and three 3-deep column shift registers. Emits one 216-bit
// window per input pixel that completes a fully interior 3x3 window.
// Optional feature macro: RGB_WINDOW_FRAME_DONE_EN adds o_frame_done, a pulse
// coincident with the last window of each frame.
module rgb_window_3x3 #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [23:0]  i_pixel_data,
  input  logic         i_pixel_data_valid,
  output logic [215:0] o_pixel_data,
  output logic         o_pixel_data_valid
`ifdef RGB_WINDOW_FRAME_DONE_EN
  ,
  output logic         o_frame_done
`endif
);

  localparam int unsigned PW = 24;
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [PW-1:0]  lb1 [IMG_WIDTH];
  logic [PW-1:0]  lb2 [IMG_WIDTH];
  logic [PW-1:0]  lb1_q;
  logic [PW-1:0]  lb2_q;
  logic [PW-1:0]  sr [3][3];
  logic [PW-1:0]  col_in_c [3];
  logic [CW-1:0]  col_cnt;
  logic [RW-1:0]  row_cnt;
  logic [CW-1:0]  col_next_c;
  logic [CW-1:0]  rd_addr_c;
  logic           col_wrap_c;
  logic           row_wrap_c;
  logic           win_c;
  logic [215:0]   win_data_c;

  // Counter wrap, prefetch address and the window word formed by this pixel.
  // The buffers are read one pixel ahead (address of the next pixel) so the
  // synchronous-read data is already waiting when that pixel arrives.
  always_comb begin
    col_wrap_c  = (col_cnt == COL_LAST);
    row_wrap_c  = (row_cnt == ROW_LAST);
    col_next_c  = col_wrap_c ? '0 : col_cnt + CW'(1);
    if (!i_rst_n) begin
      rd_addr_c = '0;
    end else if (i_pixel_data_valid) begin
      rd_addr_c = col_next_c;
    end else begin
      rd_addr_c = col_cnt;
    end
    win_c       = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
    col_in_c[0] = lb2_q;
    col_in_c[1] = lb1_q;
    col_in_c[2] = i_pixel_data;
    win_data_c  = '0;
    for (int r = 0; r < 3; r++) begin
      win_data_c[PW*(3*r+0) +: PW] = sr[r][1];
      win_data_c[PW*(3*r+1) +: PW] = sr[r][2];
      win_data_c[PW*(3*r+2) +: PW] = col_in_c[r];
    end
  end

  // Line-buffer cascade: simple dual-port RAMs with registered read data.
  always_ff @(posedge i_clk) begin
    lb1_q <= lb1[rd_addr_c];
    lb2_q <= lb2[rd_addr_c];
    if (i_rst_n && i_pixel_data_valid) begin
      lb1[col_cnt] <= i_pixel_data;
      lb2[col_cnt] <= lb1_q;
    end
  end

  // Counters, column shift registers and registered window output.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_cnt            <= '0;
      row_cnt            <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
`ifdef RGB_WINDOW_FRAME_DONE_EN
      o_frame_done       <= 1'b0;
`endif
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          sr[r][c] <= '0;
        end
      end
    end else begin
      o_pixel_data_valid <= 1'b0;
`ifdef RGB_WINDOW_FRAME_DONE_EN
      o_frame_done       <= 1'b0;
`endif
      if (i_pixel_data_valid) begin
        for (int r = 0; r < 3; r++) begin
          sr[r][0] <= sr[r][1];
          sr[r][1] <= sr[r][2];
          sr[r][2] <= col_in_c[r];
        end
        col_cnt <= col_next_c;
        if (col_wrap_c) begin
          row_cnt <= row_wrap_c ? '0 : row_cnt + RW'(1);
        end
        if (win_c) begin
          o_pixel_data       <= win_data_c;
          o_pixel_data_valid <= 1'b1;
`ifdef RGB_WINDOW_FRAME_DONE_EN
          o_frame_done       <= row_wrap_c && col_wrap_c;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_window_3x3.sv
// tb_rgb_window_3x3: scoreboard bench for rgb_window_3x3 on a 5x4 frame.
// A reference image model pushes the expected window and its output cycle
// whenever a completing pixel is driven; a negedge monitor pops and compares.
module tb_rgb_window_3x3;

  localparam int unsigned W = 5;
  localparam int unsigned H = 4;

  typedef struct packed {
    logic [215:0] data;
    logic [31:0]  cyc;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [23:0]  pix = '0;
  logic         pix_valid = 1'b0;
  logic [215:0] win;
  logic         win_valid;
`ifdef RGB_WINDOW_FRAME_DONE_EN
  logic         frame_done;
  int           done_cnt = 0;
`endif

  logic [31:0]  cyc = '0;
  logic         rst_q = 1'b0;
  logic         mon_en = 1'b0;
  logic [215:0] last_word = '0;
  int           tests = 0;
  int           fails = 0;
  int           win_cnt = 0;
  exp_t         sb [$];
  logic [215:0] got_q [$];

  logic [23:0]  img [H][W];
  int           m_row = 0;
  int           m_col = 0;

  rgb_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_valid),
    .o_pixel_data       (win),
    .o_pixel_data_valid (win_valid)
`ifdef RGB_WINDOW_FRAME_DONE_EN
    ,
    .o_frame_done       (frame_done)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 32'd1;
    rst_q <= rst_n;
  end

  // Monitor: reset values, scoreboard pop/compare, hold during gaps.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!rst_q) begin
        tests++;
        if (win_valid !== 1'b0 || win !== '0) begin
          fails++;
          $display("FAIL reset_outputs valid=%0b data=%h required valid=0 data=0", win_valid, win);
        end
`ifdef RGB_WINDOW_FRAME_DONE_EN
        tests++;
        if (frame_done !== 1'b0) begin
          fails++;
          $display("FAIL reset_frame_done got %0b required 0", frame_done);
        end
`endif
        last_word = '0;
      end else if (win_valid) begin
        win_cnt++;
        got_q.push_back(win);
        last_word = win;
`ifdef RGB_WINDOW_FRAME_DONE_EN
        if (frame_done) done_cnt++;
`endif
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_window at cycle %0d data=%h required none", cyc, win);
        end else begin
          e = sb.pop_front();
          if (win !== e.data) begin
            fails++;
            $display("FAIL window_data got %h required %h", win, e.data);
          end
          tests++;
          if (cyc !== e.cyc) begin
            fails++;
            $display("FAIL window_latency got cycle %0d required cycle %0d", cyc, e.cyc);
          end
`ifdef RGB_WINDOW_FRAME_DONE_EN
          tests++;
          if (frame_done !== e.done) begin
            fails++;
            $display("FAIL frame_done got %0b required %0b", frame_done, e.done);
          end
`endif
        end
      end else begin
        tests++;
        if (win !== last_word) begin
          fails++;
          $display("FAIL hold_data got %h required %h", win, last_word);
        end
`ifdef RGB_WINDOW_FRAME_DONE_EN
        tests++;
        if (frame_done !== 1'b0) begin
          fails++;
          $display("FAIL frame_done_idle got %0b required 0", frame_done);
        end
`endif
      end
    end
  end

  function automatic logic [23:0] gray(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b, b};
  endfunction

  function automatic logic [23:0] asym(input int v);
    return {8'(v), 8'(100 + v), 8'(200 + v)};
  endfunction

  // Drive one valid pixel and push the window it completes, if any.
  task automatic drive_pixel(input logic [23:0] p);
    exp_t e;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    pix_valid = 1'b1;
    pix       = p;
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      e.data = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.data[24*(3*r+c) +: 24] = img[m_row-2+r][m_col-2+c];
      e.cyc  = cyc + 32'd1;
      e.done = (m_row == H-1) && (m_col == W-1);
      sb.push_back(e);
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_valid = 1'b0;
    end
  endtask

  task automatic feed_frame(input int base, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      drive_pixel(gray(base + i));
      if (gaps) idle(1);
    end
  endtask

  // Expected window of frame-relative indices, gray-coded with base offset.
  function automatic logic [215:0] gray_win(input int base, input int first);
    logic [215:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[24*(3*r+c) +: 24] = gray(base + first + r*W + c);
    return w;
  endfunction

  task automatic check_drain(input string name, input int w0, input int nwin);
    idle(3);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_pending got %0d queued required 0", name, sb.size());
    end
    tests++;
    if (win_cnt - w0 != nwin) begin
      fails++;
      $display("FAIL %s_count got %0d windows required %0d", name, win_cnt - w0, nwin);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [215:0] req);
    tests++;
    if (got_q.size() <= idx) begin
      fails++;
      $display("FAIL %s missing window %0d", name, idx);
    end else if (got_q[idx] !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got_q[idx], req);
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b1;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (win !== '0 || win_valid !== 1'b0) begin
      fails++;
      $display("FAIL test_reset valid=%0b data=%h required 0/0", win_valid, win);
    end
    m_row = 0;
    m_col = 0;
  endtask

  task automatic test_continuous();
    int w0 = win_cnt;
    int n0 = got_q.size();
`ifdef RGB_WINDOW_FRAME_DONE_EN
    int d0 = done_cnt;
`endif
    feed_frame(0, 1'b0);
    check_drain("continuous", w0, 6);
    check_got("continuous_first", n0, gray_win(0, 0));
    check_got("continuous_last", n0 + 5, gray_win(0, 7));
`ifdef RGB_WINDOW_FRAME_DONE_EN
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL continuous_done_count got %0d required 1", done_cnt - d0);
    end
`endif
  endtask

  task automatic test_gapped();
    int w0 = win_cnt;
    int n0 = got_q.size();
    feed_frame(0, 1'b1);
    check_drain("gapped", w0, 6);
    check_got("gapped_first", n0, gray_win(0, 0));
    check_got("gapped_last", n0 + 5, gray_win(0, 7));
  endtask

  task automatic test_back_to_back();
    int w0 = win_cnt;
    int n0 = got_q.size();
    logic [215:0] w;
`ifdef RGB_WINDOW_FRAME_DONE_EN
    int d0 = done_cnt;
`endif
    feed_frame(40, 1'b0);
    feed_frame(80, 1'b0);
    check_drain("back_to_back", w0, 12);
    check_got("b2b_second_first", n0 + 6, gray_win(80, 0));
    for (int i = 6; i < 12; i++) begin
      if (got_q.size() > n0 + i) begin
        w = got_q[n0 + i];
        for (int k = 0; k < 9; k++) begin
          tests++;
          if (w[24*k+16 +: 8] < 8'd80) begin
            fails++;
            $display("FAIL b2b_stale window %0d pixel %0d got %0d required >=80", i, k, w[24*k+16 +: 8]);
          end
        end
      end
    end
`ifdef RGB_WINDOW_FRAME_DONE_EN
    tests++;
    if (done_cnt - d0 != 2) begin
      fails++;
      $display("FAIL b2b_done_count got %0d required 2", done_cnt - d0);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int w0 = win_cnt;
    int n0 = got_q.size();
`ifdef RGB_WINDOW_FRAME_DONE_EN
    int d0 = done_cnt;
`endif
    for (int i = 0; i <= 13; i++) drive_pixel(gray(120 + i));
    // Reset coincides with a valid pixel that must be discarded.
    @(posedge clk); #1;
    rst_n = 1'b0;
    pix_valid = 1'b1;
    pix = gray(250);
    m_row = 0;
    m_col = 0;
    @(posedge clk); #1;
    tests++;
    if (win !== '0 || win_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs valid=%0b data=%h required 0/0", win_valid, win);
    end
    rst_n = 1'b1;
    pix_valid = 1'b0;
    feed_frame(160, 1'b0);
    check_drain("mid_reset", w0, 8);
    check_got("mid_reset_first", n0 + 2, gray_win(160, 0));
    check_got("mid_reset_last", n0 + 7, gray_win(160, 7));
`ifdef RGB_WINDOW_FRAME_DONE_EN
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL mid_reset_done_count got %0d required 1", done_cnt - d0);
    end
`endif
  endtask

  task automatic test_asymmetric();
    int w0 = win_cnt;
    int n0 = got_q.size();
    logic [215:0] w;
    logic [7:0] mn;
    for (int i = 0; i < W*H; i++) drive_pixel(asym(i));
    check_drain("asymmetric", w0, 6);
    tests++;
    if (got_q.size() <= n0) begin
      fails++;
      $display("FAIL asym_first missing window");
    end else begin
      w = got_q[n0];
      if (w[23:16] !== 8'd0 || w[15:8] !== 8'd100 || w[7:0] !== 8'd200) begin
        fails++;
        $display("FAIL asym_k0 got %0d/%0d/%0d required 0/100/200", w[23:16], w[15:8], w[7:0]);
      end
      mn = 8'hff;
      for (int b = 0; b < 27; b++) if (w[8*b +: 8] < mn) mn = w[8*b +: 8];
      tests++;
      if (mn !== 8'd0) begin
        fails++;
        $display("FAIL asym_dark_min got %0d required 0", mn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_back_to_back();
    test_mid_reset();
    test_asymmetric();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_window_3x3.md
# rgb_window_3x3

Streaming 3×3 neighbourhood generator that sits directly upstream of the dark-channel stage. It accepts one 24-bit RGB pixel per valid cycle in raster order and buffers the two previous image lines. For every input pixel that completes a 3×3 window lying fully inside the image, it presents the nine pixels as one 216-bit word. No border padding is generated, so a W×H frame yields (W−2)×(H−2) windows.

## Interface
Parameters:
- IMG_WIDTH, 512: pixels per line; legal range 3..4096.
- IMG_HEIGHT, 512: lines per frame; legal range 3..4096.

Ports:
- i_clk  in  1  sole clock; all logic is on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_pixel_data  in  24  input pixel {R[23:16], G[15:8], B[7:0]}.
- i_pixel_data_valid  in  1  qualifies i_pixel_data. There is no backpressure and gaps are allowed.
- o_pixel_data  out  216  window word. Pixel k occupies bits [24k+:24], with k = 3·row + col. Row 0 is the oldest (top) line and col 0 is the leftmost (oldest) column. Each pixel keeps the B-low/G/R-high byte order.
- o_pixel_data_valid  out  1  one-cycle qualifier per window.
- o_frame_done  out  1  present only with the macro; see Configuration.

## Operation
- Column counter col_cnt runs 0..IMG_WIDTH−1 and row counter row_cnt runs 0..IMG_HEIGHT−1. Both advance only on an input valid.
  - col_cnt wraps to 0 at IMG_WIDTH−1, and row_cnt increments on that wrap.
  - row_cnt wraps to 0 at IMG_HEIGHT−1 when col_cnt also wraps, which starts the next frame. No idle cycle is needed between frames.
- Two line buffers of IMG_WIDTH×24 bits, arranged as a cascade:
  - LB1 holds line n−1 and LB2 holds line n−2.
  - On each valid, the pixel at address col_cnt is read from both buffers. LB2 is then written with the LB1 value and LB1 with the input pixel.
  - The read-before-write ordering at the same address is mandatory.
- Three 3-deep column shift registers (rows 0, 1, 2) are fed from LB2-out, LB1-out and the input. They shift only on valid.
- A window is emitted for an input when row_cnt ≥ 2 and col_cnt ≥ 2, evaluated before the increment.
- Gap cycles (valid low) freeze all counters, buffers and shift registers. Output valid is low during gaps.
- Line-buffer contents are never cleared. Stale data is masked by the row_cnt/col_cnt gating.

## Timing
- Reset state: o_pixel_data = 0, o_pixel_data_valid = 0, o_frame_done = 0, col_cnt = 0, row_cnt = 0, shift registers = 0.
- Latency: o_pixel_data_valid rises exactly 1 cycle after the input valid cycle whose pixel completes the window. o_pixel_data is registered on the same edge.
- o_pixel_data holds its last value while o_pixel_data_valid is low.
- Throughput: one window per clock at a sustained input rate of one pixel per clock.
- Reset asserted mid-frame: on the next edge, counters and outputs return to reset values and any in-flight output valid is dropped. The first valid after reset release is treated as pixel (0,0).
- Reset and valid in the same cycle: reset wins and the pixel is discarded.
- The line buffer must be inferable as simple dual-port BRAM with synchronous read. If a read pipeline stage is added, the input and counters must be delayed to match, so that the 1-cycle external latency still holds.

## Configuration
- Macro: RGB_WINDOW_FRAME_DONE_EN.
- Defined: port o_frame_done exists. It pulses high for 1 cycle, coincident with o_pixel_data_valid, for the window completed by pixel (IMG_HEIGHT−1, IMG_WIDTH−1), i.e. the last window of the frame. Reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=4; feed pixel values R=G=B=index 0..19 continuously.
  - Expect exactly 6 windows.
  - The first window follows index 12 by 1 cycle and holds indices {0,1,2,5,6,7,10,11,12} at k=0..8.
  - The last window holds {7,8,9,12,13,14,17,18,19}.
- Same frame with valid toggling every other cycle:
  - Identical 6 window values in the same order.
  - Every output valid is exactly 1 cycle after its completing input.
- Two back-to-back frames with no gap:
  - The second frame's first window equals that frame's indices {0,1,2,5,6,7,10,11,12}.
  - No window contains first-frame pixels.
- Assert i_rst_n=0 for 1 cycle after input index 13, then restart the frame:
  - All outputs are 0 the cycle after reset.
  - No window is emitted until the new index 12; the window values are correct.
- Asymmetric channels, e.g. R=index, G=100+index, B=200+index:
  - Bits [23:16]/[15:8]/[7:0] of k=0 in the first window equal 0/100/200.
  - Feeding the output through the dark-channel stage yields min = 0.
- With RGB_WINDOW_FRAME_DONE_EN defined:
  - o_frame_done pulses once per frame, only with the 6th window.
  - It stays 0 through reset and gaps.
